// File: rtl/sram_line_pkg.sv
// Shared definitions for the SRAM line sequencer.
// Holds the line geometry, the FSM state type, and a helper that builds a
// word byte address from a line address and a word index.
// Optional build macro used by the sequencer: SRAM_SKIP_MASKED_EN.
package sram_line_pkg;

  localparam int WORDS     = 16;
  localparam int WORD_W    = 48;
  localparam int DM_W      = 6;
  localparam int LINE_W    = WORDS * WORD_W;  // 768
  localparam int LINE_DM_W = WORDS * DM_W;    // 96
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  // Word byte address: 64-byte line base, 4-byte word stride.
  function automatic logic [31:0] word_addr(input logic [25:0] line_base,
                                            input logic [CNT_W-1:0] idx);
    return {line_base, idx, 2'b00};
  endfunction

endpackage

// File: rtl/sram_line_buf.sv
// Read capture buffer: 16 words x 48 bits.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears all words)
//   we        - write enable for one word
//   idx       - word index written when we=1
//   wdata     - word data
//   line      - all 16 words flattened, word i at [i*48 +: 48]
module sram_line_buf
  import sram_line_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [CNT_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [LINE_W-1:0] line
);

  logic [WORD_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_flat
    assign line[g*WORD_W +: WORD_W] = mem[g];
  end

endmodule

// File: rtl/sram_line_sequencer.sv
// Splits a 16-word line request into 16 single-word SRAM accesses.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   ws_addr       - line byte address (bits [5:0] ignored)
//   ws_din/ws_dm  - write line and per-word byte-lane masks
//   ws_stb/ws_we  - line request strobe / 1 = write, 0 = read
//   ws_ack        - one-cycle line-complete pulse
//   ws_dout       - last read line (changes only on read accepts)
//   sram_addr/din/dm/stb - word request to the SRAM controller (dm=0 means read)
//   sram_dout     - word read data, valid in the accept cycle
//   sram_nak      - controller busy; word accepted when sram_stb=1 and sram_nak=0
//   fsm_state     - current FSM state for observation
// Build macro SRAM_SKIP_MASKED_EN: write words with an all-zero mask are not
// issued (sram_stb=0 for that slot) but still take one cycle.
//
// Handshake: sram_* outputs are registered and only move after an accept
// (or a skipped slot); while sram_nak=1 they hold and the word counter stays.
module sram_line_sequencer
  import sram_line_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ws_addr,
  input  logic [LINE_W-1:0]    ws_din,
  input  logic [LINE_DM_W-1:0] ws_dm,
  input  logic                 ws_stb,
  input  logic                 ws_we,
  output logic                 ws_ack,
  output logic [LINE_W-1:0]    ws_dout,
  output logic [31:0]          sram_addr,
  output logic [WORD_W-1:0]    sram_din,
  output logic [DM_W-1:0]      sram_dm,
  output logic                 sram_stb,
  input  logic [WORD_W-1:0]    sram_dout,
  input  logic                 sram_nak,
  output state_t               fsm_state
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [25:0]          line_q;
  logic [LINE_W-1:0]    din_q;
  logic [LINE_DM_W-1:0] dm_q;
  logic                 we_q;

  logic                 accept;
  logic                 advance;
  logic [WORD_W-1:0]    nxt_din;
  logic [DM_W-1:0]      nxt_dm;
  logic [DM_W-1:0]      first_dm;
  logic                 nxt_issue;
  logic                 first_issue;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^ws_addr[5:0];
  assign fsm_state        = state;

  assign accept  = (state == ACCESS) && sram_stb && !sram_nak;
  assign cnt_nxt = cnt + 4'd1;

  // Word presented after the current one is accepted (read lanes forced to 0).
  assign nxt_din  = din_q[cnt_nxt*WORD_W +: WORD_W];
  assign nxt_dm   = we_q ? dm_q[cnt_nxt*DM_W +: DM_W] : '0;
  assign first_dm = ws_we ? ws_dm[DM_W-1:0] : '0;

`ifdef SRAM_SKIP_MASKED_EN
  // A slot with sram_stb=0 in ACCESS is a skipped write word: it advances
  // without waiting for the controller.
  assign advance     = accept || ((state == ACCESS) && !sram_stb);
  assign nxt_issue   = !(we_q && (nxt_dm == '0));
  assign first_issue = !(ws_we && (first_dm == '0));
`else
  assign advance     = accept;
  assign nxt_issue   = 1'b1;
  assign first_issue = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      line_q    <= '0;
      din_q     <= '0;
      dm_q      <= '0;
      we_q      <= 1'b0;
      ws_ack    <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      sram_dm   <= '0;
      sram_stb  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ws_ack <= 1'b0;
          if (ws_stb) begin
            line_q    <= ws_addr[31:6];
            din_q     <= ws_din;
            dm_q      <= ws_dm;
            we_q      <= ws_we;
            cnt       <= '0;
            sram_addr <= word_addr(ws_addr[31:6], 4'd0);
            sram_din  <= ws_din[WORD_W-1:0];
            sram_dm   <= first_dm;
            sram_stb  <= first_issue;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (advance) begin
            if (cnt == 4'd15) begin
              state    <= ACK;
              ws_ack   <= 1'b1;
              sram_stb <= 1'b0;
              sram_dm  <= '0;
            end else begin
              cnt       <= cnt_nxt;
              sram_addr <= word_addr(line_q, cnt_nxt);
              sram_din  <= nxt_din;
              sram_dm   <= nxt_dm;
              sram_stb  <= nxt_issue;
            end
          end
        end
        ACK: begin
          ws_ack <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state    <= IDLE;
          ws_ack   <= 1'b0;
          sram_stb <= 1'b0;
        end
      endcase
    end
  end

  // Only read accepts touch the capture buffer, so ws_dout holds across
  // writes and idle time.
  sram_line_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && !we_q),
    .idx   (cnt),
    .wdata (sram_dout),
    .line  (ws_dout)
  );

endmodule

// File: doc/sram_line_sequencer.md
SRAM_LINE_SEQUENCER -- requirements
Module: sram_line_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, using the ports below.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 ws_addr  in  32  line byte address; bits [5:0] ignored.
REQ-005 ws_din  in  768  write line, 16 words x 48 bits; word i = ws_din[i*48+47:i*48].
REQ-006 ws_dm  in  96  write byte-lane masks, 6 bits per word; word i = ws_dm[i*6+5:i*6].
REQ-007 ws_stb  in  1  line request strobe.
REQ-008 ws_we  in  1  1 = write line, 0 = read line.
REQ-009 ws_ack  out  1  one-cycle line-complete pulse.
REQ-010 ws_dout  out  768  read line data, same word packing as ws_din.
REQ-011 sram_addr  out  32  word byte address.
REQ-012 sram_din  out  48  word write data.
REQ-013 sram_dm  out  6  word lane enables; all zero means read.
REQ-014 sram_stb  out  1  word request.
REQ-015 sram_dout  in  48  word read data, valid in the accept cycle.
REQ-016 sram_nak  in  1  controller busy; a word is accepted on a cycle with sram_stb=1 and sram_nak=0.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and ACK.
REQ-018 In IDLE, when ws_stb=1, the block SHALL capture ws_addr[31:6], ws_din, ws_dm and ws_we, clear word counter cnt (4 bits) to 0, and go to ACCESS.
REQ-019 In ACCESS, the block SHALL drive sram_stb=1 and sram_addr={line[31:6],cnt,2'b00}.
REQ-020 In ACCESS, sram_din SHALL equal captured word cnt, and sram_dm SHALL equal captured mask cnt for writes and 6'b0 for reads.
REQ-021 While sram_nak=1, all sram_* outputs SHALL hold stable and cnt SHALL NOT advance.
REQ-022 On a read accept, sram_dout SHALL be stored into buffer word cnt.
REQ-023 On accept with cnt<15, cnt SHALL increment; on accept with cnt==15, the FSM SHALL go to ACK.
REQ-024 In ACK, ws_ack=1 for exactly one cycle, sram_stb=0, ws_dout=buffer; the next state SHALL be IDLE.
REQ-025 ws_stb SHALL be ignored outside IDLE. A ws_stb still high in the cycle after ACK SHALL start a new transaction using the address present then, which permits back-to-back line writes.
REQ-026 ws_dout SHALL change only on read accepts and SHALL hold its value across write transactions and idle cycles.
REQ-027 Latency with no nak SHALL be: request sampled in cycle 0, words in cycles 1..16, ws_ack in cycle 17. Each nak cycle adds one cycle.
REQ-028 cnt SHALL NOT wrap within a transaction, and exactly 16 word slots SHALL be processed per line.

Reset
REQ-029 When rst=1 on a clock edge, the next state SHALL be IDLE and cnt=0 at that edge, regardless of current state, including mid-ACCESS.
REQ-030 After that edge, outputs SHALL be ws_ack=0, sram_stb=0, sram_dm=0, sram_addr=0, sram_din=0 and ws_dout=0.
REQ-031 A transaction interrupted by rst SHALL be abandoned with no ws_ack.

Configuration
REQ-032 Macro SRAM_SKIP_MASKED_EN, when defined, SHALL cause write words whose captured mask is 6'b0 to be skipped.
REQ-033 A skipped word SHALL have sram_stb=0 for that slot and SHALL advance cnt in one cycle, so line latency stays 17 cycles without nak.
REQ-034 Without SRAM_SKIP_MASKED_EN, every word SHALL be issued. Reads SHALL never be skipped in either configuration.

Structure
REQ-035 Package sram_line_pkg SHALL hold WORDS=16, WORD_W=48, DM_W=6, LINE_W=768, LINE_DM_W=96 and the FSM state typedef.
REQ-036 Sub-module sram_line_buf SHALL hold the 16x48 read capture buffer with indexed word write and flattened 768-bit output.

Verification
REQ-037 Read, no nak: rst then ws_stb=1, ws_we=0, ws_addr=32'h003FFFC0, sram_dout=48'h000112345678 on every accept -> sram_addr steps 3FFFC0..3FFFFC, ws_ack in cycle 17, and all 16 ws_dout words = 48'h000112345678.
REQ-038 Write with nak: ws_we=1, ws_dm=all ones, ws_din words = 48'h000087654321, sram_nak=1 for 3 cycles on word 5 -> sram_addr/din hold during nak, all 16 words issued with dm=6'h3F, ws_ack in cycle 20, ws_dout unchanged.
REQ-039 Back-to-back: ws_stb held high and ws_addr incremented by 64 on each ws_ack -> consecutive lines at 0x0, 0x40, 0x80, one IDLE cycle between them, no lost or duplicated word.
REQ-040 Reset mid-op: rst=1 at cnt=7 of a read -> next cycle IDLE, sram_stb=0, ws_dout=0, no ws_ack; the next request completes normally.
REQ-041 Masked write: ws_dm word0=6'h3F, all others 0 -> with SRAM_SKIP_MASKED_EN only one sram_stb pulse, at addr offset 0, and ws_ack in cycle 17; without the macro, 16 pulses with words 1..15 dm=0.
